// File: rtl/defs.sv
// Shared definitions for the front end: fetch FSM states, the reset fetch
// address and the packet handed from IF to the IF/ID register.
package defs;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        DISCARD = 2'd2
    } FetchState;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        predTaken;
        logic [3:0]  excCode;
    } IFResult;

endpackage

// File: rtl/fetch_stage.sv
// Instruction fetch stage: keeps at most one instruction-memory request in
// flight and one fetched instruction buffered for the IF/ID register.
// A redirect flushes the buffer; a response to a request issued before the
// redirect is still waited for, but its data is thrown away (DISCARD).
module fetch_stage
    import defs::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        hold,
    input  logic        redirect,
    input  logic [31:0] target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_data,
    output IFResult     IFOut,
    output logic        ifValid,
    output logic        alignErr
);

    FetchState   state;
    FetchState   stateNext;
    logic [31:0] pc;
    logic [31:0] pcNext;
    logic [31:0] reqAddr;
    logic [31:0] reqAddrNext;
    logic        bufValid;
    logic        bufValidNext;
    logic [31:0] bufPc;
    logic [31:0] bufPcNext;
    logic [31:0] bufInstr;
    logic [31:0] bufInstrNext;
    logic        alignErrNext;
    logic        slotFree;

    // The buffer can take a new instruction if it is empty or is being consumed now.
    assign slotFree = !bufValid || !hold;

    // Next-state logic: redirect wins over hold and ack, otherwise the FSM issues and retires fetches.
    always_comb begin
        stateNext    = state;
        pcNext       = pc;
        reqAddrNext  = reqAddr;
        bufValidNext = bufValid && hold;
        bufPcNext    = bufPc;
        bufInstrNext = bufInstr;
        alignErrNext = redirect && (target[1:0] != 2'b00);

        if (redirect) begin
            bufValidNext = 1'b0;
            pcNext       = {target[31:2], 2'b00};
            case (state)
                WAIT:    stateNext = imem_ack ? IDLE : DISCARD;
                DISCARD: stateNext = imem_ack ? IDLE : DISCARD;
                default: stateNext = IDLE;
            endcase
        end else begin
            case (state)
                IDLE: begin
                    if (slotFree) begin
                        stateNext   = WAIT;
                        reqAddrNext = pc;
                        pcNext      = pc + 32'd4;
                    end
                end
                WAIT: begin
                    if (imem_ack) begin
                        bufValidNext = 1'b1;
                        bufPcNext    = reqAddr;
                        bufInstrNext = imem_data;
                        if (slotFree) begin
                            stateNext   = WAIT;
                            reqAddrNext = pc;
                            pcNext      = pc + 32'd4;
                        end else begin
                            stateNext = IDLE;
                        end
                    end
                end
                DISCARD: begin
                    if (imem_ack) begin
                        stateNext = IDLE;
                    end
                end
                default: stateNext = IDLE;
            endcase
        end
    end

    // State, address and buffer registers, cleared immediately on reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            reqAddr  <= 32'd0;
            bufValid <= 1'b0;
            bufPc    <= 32'd0;
            bufInstr <= 32'd0;
            alignErr <= 1'b0;
        end else begin
            state    <= stateNext;
            pc       <= pcNext;
            reqAddr  <= reqAddrNext;
            bufValid <= bufValidNext;
            bufPc    <= bufPcNext;
            bufInstr <= bufInstrNext;
            alignErr <= alignErrNext;
        end
    end

    assign imem_req  = (state == WAIT) || (state == DISCARD);
    assign imem_addr = reqAddr;
    assign ifValid   = bufValid;

    // Present the buffered instruction, or an all-zero bubble when empty.
    always_comb begin
        IFOut = '0;
        if (bufValid) begin
            IFOut.pc    = bufPc;
            IFOut.instr = bufInstr;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed test of fetch_stage: zero-wait streaming, two-cycle memory,
// hold, redirects (aligned, misaligned, with ack), reset mid-request and
// pc wrap-around. Memory returns {16'hC0DE, addr[15:0]} for every address.
module tb_fetch_stage;
    import defs::*;

    logic        clock;
    logic        reset;
    logic        hold;
    logic        redirect;
    logic [31:0] target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;
    IFResult     IFOut;
    logic        ifValid;
    logic        alignErr;

    logic        zeroWait;
    logic        ackManual;
    int          checks;
    int          passes;

    fetch_stage #(.RESET_PC(32'h0000_3000)) dut (
        .clock     (clock),
        .reset     (reset),
        .hold      (hold),
        .redirect  (redirect),
        .target    (target),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_ack  (imem_ack),
        .imem_data (imem_data),
        .IFOut     (IFOut),
        .ifValid   (ifValid),
        .alignErr  (alignErr)
    );

    // Memory model: either acks in the request cycle or under direct control.
    assign imem_ack  = zeroWait ? imem_req : ackManual;
    assign imem_data = {16'hC0DE, imem_addr[15:0]};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic h, input logic r, input logic [31:0] t, input logic a);
        hold      = h;
        redirect  = r;
        target    = t;
        ackManual = a;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        checks    = 0;
        passes    = 0;
        reset     = 1'b1;
        zeroWait  = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);

        // Reset state
        repeat (2) tick();
        checkOutput("rst_req",   {31'd0, imem_req}, 32'd0);
        checkOutput("rst_valid", {31'd0, ifValid},  32'd0);
        checkOutput("rst_pc",    IFOut.pc,          32'd0);
        checkOutput("rst_align", {31'd0, alignErr}, 32'd0);
        reset = 1'b0;

        // Zero-wait memory streams one instruction per cycle
        tick();
        checkOutput("zw_addr0",  imem_addr,         32'h0000_3000);
        checkOutput("zw_valid0", {31'd0, ifValid},  32'd0);
        tick();
        checkOutput("zw_addr1",  imem_addr,         32'h0000_3004);
        checkOutput("zw_pc1",    IFOut.pc,          32'h0000_3000);
        checkOutput("zw_instr1", IFOut.instr,       32'hC0DE_3000);
        checkOutput("zw_valid1", {31'd0, ifValid},  32'd1);
        tick();
        checkOutput("zw_addr2",  imem_addr,         32'h0000_3008);
        checkOutput("zw_pc2",    IFOut.pc,          32'h0000_3004);
        checkOutput("zw_valid2", {31'd0, ifValid},  32'd1);
        tick();
        checkOutput("zw_addr3",  imem_addr,         32'h0000_300C);
        checkOutput("zw_pc3",    IFOut.pc,          32'h0000_3008);
        checkOutput("zw_valid3", {31'd0, ifValid},  32'd1);

        // Asynchronous reset clears outputs without a clock edge
        #2;
        reset    = 1'b1;
        zeroWait = 1'b0;
        #1;
        checkOutput("arst_req",   {31'd0, imem_req}, 32'd0);
        checkOutput("arst_valid", {31'd0, ifValid},  32'd0);
        checkOutput("arst_pc",    IFOut.pc,          32'd0);
        tick();
        reset = 1'b0;

        // Two-cycle memory: each address held two cycles, one valid cycle per ack
        tick();
        checkOutput("lat_addr_first", imem_addr,        32'h0000_3000);
        checkOutput("lat_req_first",  {31'd0, imem_req}, 32'd1);
        for (int i = 0; i < 2; i++) begin
            tick();
            checkOutput("lat_addr_held", imem_addr,        32'h0000_3000 + 32'(4 * i));
            checkOutput("lat_valid_lo",  {31'd0, ifValid}, 32'd0);
            ackManual = 1'b1;
            tick();
            checkOutput("lat_valid_hi",  {31'd0, ifValid}, 32'd1);
            checkOutput("lat_pc",        IFOut.pc,         32'h0000_3000 + 32'(4 * i));
            checkOutput("lat_instr",     IFOut.instr,      32'hC0DE_3000 + 32'(4 * i));
            checkOutput("lat_addr_next", imem_addr,        32'h0000_3004 + 32'(4 * i));
            ackManual = 1'b0;
        end

        // Hold keeps pc=3004 on IFOut and issues nothing new
        applyStimulus(1'b1, 1'b0, 32'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("hold_pc",    IFOut.pc,         32'h0000_3004);
            checkOutput("hold_instr", IFOut.instr,      32'hC0DE_3004);
            checkOutput("hold_valid", {31'd0, ifValid}, 32'd1);
            checkOutput("hold_addr",  imem_addr,        32'h0000_3008);
        end
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
        tick();
        checkOutput("consume_valid", {31'd0, ifValid}, 32'd0);
        checkOutput("consume_addr",  imem_addr,        32'h0000_3008);

        // Redirect to 0x4000 while 0x3008 is outstanding
        applyStimulus(1'b0, 1'b1, 32'h0000_4000, 1'b0);
        tick();
        checkOutput("redir_valid", {31'd0, ifValid},  32'd0);
        checkOutput("redir_req",   {31'd0, imem_req}, 32'd1);
        checkOutput("redir_addr",  imem_addr,         32'h0000_3008);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
        tick();
        checkOutput("drop_valid", {31'd0, ifValid},  32'd0);
        checkOutput("drop_req",   {31'd0, imem_req}, 32'd0);
        ackManual = 1'b0;
        tick();
        checkOutput("refetch_addr", imem_addr,         32'h0000_4000);
        checkOutput("refetch_req",  {31'd0, imem_req}, 32'd1);
        ackManual = 1'b1;
        tick();
        checkOutput("refetch_pc",    IFOut.pc,         32'h0000_4000);
        checkOutput("refetch_instr", IFOut.instr,      32'hC0DE_4000);
        checkOutput("refetch_valid", {31'd0, ifValid}, 32'd1);
        checkOutput("refetch_next",  imem_addr,        32'h0000_4004);

        // Misaligned redirect with hold also set: redirect still flushes
        applyStimulus(1'b1, 1'b1, 32'h0000_4002, 1'b0);
        tick();
        checkOutput("mis_align", {31'd0, alignErr}, 32'd1);
        checkOutput("mis_valid", {31'd0, ifValid},  32'd0);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
        tick();
        checkOutput("mis_align_off", {31'd0, alignErr}, 32'd0);
        checkOutput("mis_req_idle",  {31'd0, imem_req}, 32'd0);
        ackManual = 1'b0;
        tick();
        checkOutput("mis_addr", imem_addr, 32'h0000_4000);

        // Redirect coinciding with ack drops the data and goes idle
        applyStimulus(1'b0, 1'b1, 32'h0000_5000, 1'b1);
        tick();
        checkOutput("rack_req",   {31'd0, imem_req}, 32'd0);
        checkOutput("rack_valid", {31'd0, ifValid},  32'd0);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
        tick();
        checkOutput("rack_addr", imem_addr, 32'h0000_5000);

        // Reset mid-WAIT followed by a late ack
        #2;
        reset = 1'b1;
        #1;
        checkOutput("mwr_req",   {31'd0, imem_req}, 32'd0);
        checkOutput("mwr_valid", {31'd0, ifValid},  32'd0);
        ackManual = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        checkOutput("mwr_restart", imem_addr,        32'h0000_3000);
        checkOutput("mwr_valid1",  {31'd0, ifValid}, 32'd0);
        ackManual = 1'b0;
        tick();
        checkOutput("mwr_valid2", {31'd0, ifValid}, 32'd0);
        checkOutput("mwr_addr2",  imem_addr,        32'h0000_3000);

        // pc wraps from 0xFFFF_FFFC to 0
        applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
        tick();
        checkOutput("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        ackManual = 1'b1;
        tick();
        checkOutput("wrap_next",  imem_addr,   32'h0000_0000);
        checkOutput("wrap_pc",    IFOut.pc,    32'hFFFF_FFFC);
        checkOutput("wrap_instr", IFOut.instr, 32'hC0DE_FFFC);
        ackManual = 1'b0;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
